l2r_datapath: RTL and testbench
===============================

L2R_DATAPATH -- requirements
Module: l2r_datapath

Interface
REQ-001 Parameter WIDTH, default 4: exponent width in bits and number of square/multiply iterations.
REQ-002 Parameter DWIDTH, default 16: base/result data width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 base_in  input  DWIDTH  base operand, captured on LoadA.
REQ-006 exp_in  input  WIDTH  exponent operand, captured on LoadB.
REQ-007 LoadA  input  1  load register A from base_in.
REQ-008 LoadB  input  1  load register B from exp_in.
REQ-009 ShiftB  input  1  shift B left by one, LSB filled with 0.
REQ-010 LoadCoun  input  1  load iteration counter from the S_Coun-selected source.
REQ-011 S_Coun  input  1  counter source: 0 = zero, 1 = counter+1.
REQ-012 LoadC  input  1  load accumulator C from the S_C-selected source.
REQ-013 S_C  input  2  C source: 00 = constant 1, 01 = C*C, 10 = C*A, 11 = C (hold).
REQ-014 equals  output  1  high when counter == WIDTH.
REQ-015 regBk  output  1  current MSB of B, B[WIDTH-1].
REQ-016 result  output  DWIDTH  current value of C.
REQ-017 ovf  output  1  sticky overflow: some product loaded into C exceeded DWIDTH bits.

Function
REQ-018 Registers: A (DWIDTH), B (WIDTH), C (DWIDTH), counter (clog2(WIDTH+1) bits), ovf (1); each SHALL change only on a rising clk edge.
REQ-019 Control inputs SHALL be sampled on the same edge that applies them; each register update SHALL take effect in one cycle.
REQ-020 equals and regBk SHALL be combinational decodes of registered state only, with no path from any control input.
REQ-021 A SHALL load base_in when LoadA=1 and hold otherwise.
REQ-022 B: LoadB=1 SHALL load exp_in; else ShiftB=1 SHALL load {B[WIDTH-2:0],0}; else hold. LoadB has priority when both are asserted.
REQ-023 Counter: LoadCoun=1 SHALL load 0 (S_Coun=0) or counter+1 (S_Coun=1); else hold. The counter SHALL saturate at WIDTH and never wrap.
REQ-024 C: LoadC=1 SHALL load the S_C-selected value; else hold. Products SHALL be truncated to the low DWIDTH bits.
REQ-025 ovf SHALL clear on LoadA=1 and SHALL set when LoadC=1 with S_C in {01,10} and the upper DWIDTH bits of the 2*DWIDTH product are nonzero. Clear takes priority when both occur on the same edge.
REQ-026 All control bits low SHALL hold every register unchanged.
REQ-027 With an in-order control sequence of load, then per iteration (square+increment, then shift with optional C*A), result SHALL equal base^exp mod 2^DWIDTH after WIDTH iterations; exp=0 SHALL yield 1.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set A=0, B=0, C=0, counter=0 and ovf=0, overriding all control inputs, including mid-operation.
REQ-029 After reset, outputs SHALL be result=0, ovf=0, regBk=0 and equals=0 (for WIDTH>0).

Structure
REQ-030 Shared package l2r_pkg SHALL hold the S_C encodings (SC_ONE, SC_SQR, SC_MUL, SC_HOLD), the S_Coun encodings and the default WIDTH/DWIDTH.
REQ-031 Sub-module l2r_mult SHALL implement the DWIDTH x DWIDTH combinational multiply, returning the truncated product and an overflow flag; a single instance SHALL be shared by S_C=01 and S_C=10 through an operand mux.

Verification (WIDTH=4, DWIDTH=16)
REQ-032 Reset: arbitrary state, rst_n=0 for one edge -> A=B=C=0, counter=0, ovf=0, equals=0, regBk=0.
REQ-033 Load: base_in=3, exp_in=4'b0101, LoadA=LoadB=LoadCoun=LoadC=1, S_C=00, S_Coun=0 -> A=3, B=0101, C=1, counter=0, regBk=0.
REQ-034 Full exponentiation, driven by the l2r control unit with base 3 and exp 0101 -> equals rises after 4 increments, result=243, ovf=0; exp 0000 -> result=1.
REQ-035 Overflow: base 300, exp 1111 -> ovf=1, result=(300^15 mod 65536); a following LoadA -> ovf=0.
REQ-036 Priority/hold: LoadB=ShiftB=1 -> B=exp_in; LoadC=1 with S_C=11 -> C unchanged; LoadCoun+S_Coun=1 at counter=4 -> counter stays 4.
REQ-037 Reset mid-operation: rst_n=0 during iteration 2 -> all registers 0 on the next edge; a new load sequence then completes correctly.

Source files
------------

// File: rtl/l2r_pkg.sv
// Shared encodings and defaults for the left-to-right exponentiation datapath.
package l2r_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DWIDTH = 16;

  // Accumulator C source select.
  typedef enum logic [1:0] {
    SC_ONE  = 2'b00,
    SC_SQR  = 2'b01,
    SC_MUL  = 2'b10,
    SC_HOLD = 2'b11
  } sc_sel_e;

  // Iteration counter source select.
  typedef enum logic {
    SCOUN_ZERO = 1'b0,
    SCOUN_INC  = 1'b1
  } scoun_sel_e;

  // True for the C sources that load a multiplier product.
  function automatic logic sc_is_product(input logic [1:0] sel);
    return (sel == SC_SQR) || (sel == SC_MUL);
  endfunction

endpackage

// File: rtl/l2r_datapath_mult.sv
// Combinational DWIDTH x DWIDTH multiplier: truncated product plus an
// overflow flag raised when the upper half of the full product is nonzero.
module l2r_mult
  import l2r_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic [DWIDTH-1:0] prod,
  output logic              ovf_flag
);

  logic [2*DWIDTH-1:0] full_prod;

  // Full-width product, split into the kept low half and the overflow test.
  always_comb begin
    full_prod = {{DWIDTH{1'b0}}, op_a} * {{DWIDTH{1'b0}}, op_b};
    prod      = full_prod[DWIDTH-1:0];
    ovf_flag  = |full_prod[2*DWIDTH-1:DWIDTH];
  end

endmodule

// File: rtl/l2r_datapath.sv
// Datapath for left-to-right square-and-multiply exponentiation.
// An external control unit sequences the load/shift/select strobes; this
// block holds the base (A), the exponent shifter (B), the accumulator (C),
// the iteration counter and a sticky overflow flag.
module l2r_datapath
  import l2r_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] base_in,
  input  logic [WIDTH-1:0]  exp_in,
  input  logic              LoadA,
  input  logic              LoadB,
  input  logic              ShiftB,
  input  logic              LoadCoun,
  input  logic              S_Coun,
  input  logic              LoadC,
  input  logic [1:0]        S_C,
  output logic              equals,
  output logic              regBk,
  output logic [DWIDTH-1:0] result,
  output logic              ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [DWIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [DWIDTH-1:0] c_q, c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [DWIDTH-1:0] mul_op_b;
  logic [DWIDTH-1:0] mul_prod;
  logic              mul_ovf;

  // Single shared multiplier: C*C for squaring, C*A for the conditional multiply.
  always_comb begin
    mul_op_b = (S_C == SC_MUL) ? a_q : c_q;
  end

  l2r_mult #(
    .DWIDTH (DWIDTH)
  ) u_mult (
    .op_a     (c_q),
    .op_b     (mul_op_b),
    .prod     (mul_prod),
    .ovf_flag (mul_ovf)
  );

  // Base register: load or hold.
  always_comb begin
    a_d = a_q;
    if (LoadA) a_d = base_in;
  end

  // Exponent register: load wins over shift; shift brings the next bit to the MSB.
  always_comb begin
    b_d = b_q;
    if (LoadB)       b_d = exp_in;
    else if (ShiftB) b_d = b_q << 1;
  end

  // Iteration counter: clear or increment, saturating at WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    if (LoadCoun) begin
      if (S_Coun == SCOUN_INC) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Accumulator: constant one, truncated product, or hold.
  always_comb begin
    c_d = c_q;
    if (LoadC) begin
      case (S_C)
        SC_ONE:  c_d = DWIDTH'(1);
        SC_SQR:  c_d = mul_prod;
        SC_MUL:  c_d = mul_prod;
        default: c_d = c_q;
      endcase
    end
  end

  // Sticky overflow: a new base clears it, and the clear beats a same-edge set.
  always_comb begin
    ovf_d = ovf_q;
    if (LoadA)                                  ovf_d = 1'b0;
    else if (LoadC && sc_is_product(S_C) && mul_ovf) ovf_d = 1'b1;
  end

  // State registers with synchronous reset overriding every strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Status decodes look only at registered state.
  always_comb begin
    equals = (cnt_q == CNT_MAX);
    regBk  = b_q[WIDTH-1];
    result = c_q;
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_l2r_datapath.sv
// Self-checking bench for l2r_datapath (WIDTH=4, DWIDTH=16).
module tb_l2r_datapath;

  logic        clk;
  logic        rst_n;
  logic [15:0] base_in;
  logic [3:0]  exp_in;
  logic        LoadA, LoadB, ShiftB, LoadCoun, S_Coun, LoadC;
  logic [1:0]  S_C;
  logic        equals, regBk, ovf;
  logic [15:0] result;

  int tests_run;
  int tests_failed;

  // Register-level reference state.
  longint unsigned m_a, m_b, m_c, m_cnt;
  bit              m_ovf;

  l2r_datapath #(.WIDTH(4), .DWIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .base_in  (base_in),
    .exp_in   (exp_in),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .ShiftB   (ShiftB),
    .LoadCoun (LoadCoun),
    .S_Coun   (S_Coun),
    .LoadC    (LoadC),
    .S_C      (S_C),
    .equals   (equals),
    .regBk    (regBk),
    .result   (result),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  // Apply one cycle of controls, update the reference, then return to idle.
  task automatic drive(input bit rn, input bit la, input bit lb, input bit sb,
                       input bit lcn, input bit scn, input bit lc,
                       input logic [1:0] sc, input logic [15:0] b,
                       input logic [3:0] e);
    longint unsigned prod;
    rst_n = rn; LoadA = la; LoadB = lb; ShiftB = sb;
    LoadCoun = lcn; S_Coun = scn; LoadC = lc; S_C = sc;
    base_in = b; exp_in = e;
    @(posedge clk);
    if (!rn) begin
      m_a = 0; m_b = 0; m_c = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      prod = (sc == 2'b10) ? m_c * m_a : m_c * m_c;
      if (la) m_ovf = 0;
      else if (lc && (sc == 2'b01 || sc == 2'b10) && prod > 65535) m_ovf = 1;
      if (lc) begin
        case (sc)
          2'b00: m_c = 1;
          2'b01, 2'b10: m_c = prod % 65536;
          default: ;
        endcase
      end
      if (lcn) m_cnt = scn ? ((m_cnt + 1 > 4) ? 4 : m_cnt + 1) : 0;
      if (lb) m_b = e;
      else if (sb) m_b = (m_b * 2) % 16;
      if (la) m_a = b;
    end
    #1;
    rst_n = 1'b1; LoadA = 0; LoadB = 0; ShiftB = 0;
    LoadCoun = 0; S_Coun = 0; LoadC = 0; S_C = 2'b00;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 4'h0);
  endtask

  // Arithmetic reference: base^exp mod 2^16 and whether any
  // square/multiply step of the left-to-right schedule exceeded 16 bits.
  function automatic void pow_ref(input longint unsigned b, input int e,
                                  output longint unsigned r, output bit o);
    longint unsigned c;
    c = 1; o = 0;
    for (int i = 3; i >= 0; i--) begin
      c = c * c;
      if (c > 65535) o = 1;
      c = c % 65536;
      if ((e >> i) & 1) begin
        c = c * b;
        if (c > 65535) o = 1;
        c = c % 65536;
      end
    end
    r = c;
  endfunction

  // Control unit: load, then per iteration square+increment, shift with optional multiply.
  task automatic l2r_ctrl(input logic [15:0] b, input logic [3:0] e,
                          output logic [3:0] eq_seen);
    bit mul;
    eq_seen = 4'b0;
    drive(1, 1, 1, 0, 1, 0, 1, 2'b00, b, e);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 1, 1, 2'b01, 16'h0, 4'h0);
      eq_seen[i] = equals;
      mul = regBk;
      drive(1, 0, 0, 1, 0, 0, mul, 2'b10, 16'h0, 4'h0);
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 0, 1, 0, 1, 2'b00, 16'd77, 4'b1000);
    drive(1, 0, 0, 0, 1, 1, 1, 2'b10, 16'h0, 4'h0);
    drive(0, 1, 1, 1, 1, 1, 1, 2'b01, 16'hffff, 4'hf);
    tests_run++;
    if (result !== 16'd0) begin tests_failed++; $display("FAIL reset_result: got %0d want 0", result); end
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests_run++;
    if (equals !== 1'b0) begin tests_failed++; $display("FAIL reset_equals: got %b want 0", equals); end
    tests_run++;
    if (regBk !== 1'b0) begin tests_failed++; $display("FAIL reset_regBk: got %b want 0", regBk); end
  endtask

  task automatic test_load();
    drive(1, 1, 1, 0, 1, 0, 1, 2'b00, 16'd3, 4'b0101);
    tests_run++;
    if (result !== 16'd1) begin tests_failed++; $display("FAIL load_c: got %0d want 1", result); end
    tests_run++;
    if (regBk !== 1'b0 || equals !== 1'b0) begin
      tests_failed++; $display("FAIL load_flags: got regBk=%b equals=%b want 0 0", regBk, equals);
    end
    drive(1, 0, 0, 1, 0, 0, 0, 2'b00, 16'h0, 4'h0);
    tests_run++;
    if (regBk !== 1'b1) begin tests_failed++; $display("FAIL load_b_shift: got %b want 1", regBk); end
    drive(1, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0, 4'h0);
    tests_run++;
    if (result !== 16'd3) begin tests_failed++; $display("FAIL load_a: got %0d want 3", result); end
  endtask

  task automatic test_exponent();
    logic [3:0] eq_seen;
    longint unsigned r;
    bit o;
    logic [15:0] b;
    logic [3:0]  e;
    l2r_ctrl(16'd3, 4'b0101, eq_seen);
    tests_run++;
    if (eq_seen !== 4'b1000) begin tests_failed++; $display("FAIL exp_equals_rise: got %b want 1000", eq_seen); end
    tests_run++;
    if (result !== 16'd243 || ovf !== 1'b0) begin
      tests_failed++; $display("FAIL exp_3_5: got %0d ovf=%b want 243 ovf=0", result, ovf);
    end
    l2r_ctrl(16'd3, 4'b0000, eq_seen);
    tests_run++;
    if (result !== 16'd1) begin tests_failed++; $display("FAIL exp_zero: got %0d want 1", result); end
    for (int k = 0; k < 8; k++) begin
      b = 16'($urandom_range(0, 65535));
      if (k < 4) b = 16'($urandom_range(0, 12));
      e = 4'($urandom_range(0, 15));
      l2r_ctrl(b, e, eq_seen);
      pow_ref(b, int'(e), r, o);
      tests_run++;
      if (result !== 16'(r) || ovf !== o) begin
        tests_failed++;
        $display("FAIL exp_random %0d^%0d: got %0d ovf=%b want %0d ovf=%b", b, e, result, ovf, r, o);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] eq_seen;
    longint unsigned r;
    bit o;
    pow_ref(300, 15, r, o);
    l2r_ctrl(16'd300, 4'b1111, eq_seen);
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_set: got %b want 1", ovf); end
    tests_run++;
    if (result !== 16'(r)) begin tests_failed++; $display("FAIL ovf_result: got %0d want %0d", result, r); end
    idle();
    tests_run++;
    if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    // Same-edge clear and set: the clear must win.
    drive(1, 1, 0, 0, 0, 0, 1, 2'b01, 16'd5, 4'h0);
    tests_run++;
    if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", ovf); end
  endtask

  task automatic test_priority_hold();
    logic [15:0] c_before;
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 16'h0, 4'b0100);
    drive(1, 0, 1, 1, 0, 0, 0, 2'b00, 16'h0, 4'b0011);
    tests_run++;
    if (regBk !== 1'b0) begin tests_failed++; $display("FAIL prio_loadb_a: got %b want 0", regBk); end
    drive(1, 0, 1, 1, 0, 0, 0, 2'b00, 16'h0, 4'b1000);
    tests_run++;
    if (regBk !== 1'b1) begin tests_failed++; $display("FAIL prio_loadb_b: got %b want 1", regBk); end
    drive(1, 1, 0, 0, 0, 0, 1, 2'b00, 16'd7, 4'h0);
    drive(1, 0, 0, 0, 0, 0, 1, 2'b10, 16'h0, 4'h0);
    c_before = 16'd7;
    drive(1, 0, 0, 0, 0, 0, 1, 2'b11, 16'h0, 4'h0);
    tests_run++;
    if (result !== c_before) begin tests_failed++; $display("FAIL hold_c: got %0d want %0d", result, c_before); end
    drive(1, 0, 0, 0, 1, 0, 0, 2'b00, 16'h0, 4'h0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 1, 1, 0, 2'b00, 16'h0, 4'h0);
    tests_run++;
    if (equals !== 1'b1) begin tests_failed++; $display("FAIL cnt_reach: got %b want 1", equals); end
    drive(1, 0, 0, 0, 1, 1, 0, 2'b00, 16'h0, 4'h0);
    drive(1, 0, 0, 0, 1, 1, 0, 2'b00, 16'h0, 4'h0);
    tests_run++;
    if (equals !== 1'b1) begin tests_failed++; $display("FAIL cnt_saturate: got %b want 1", equals); end
    // All strobes low: nothing moves.
    for (int i = 0; i < 3; i++) idle();
    tests_run++;
    if (result !== 16'd7 || equals !== 1'b1 || regBk !== 1'b1) begin
      tests_failed++; $display("FAIL idle_hold: got result=%0d equals=%b regBk=%b want 7 1 1", result, equals, regBk);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] eq_seen;
    longint unsigned r;
    bit o;
    drive(1, 1, 1, 0, 1, 0, 1, 2'b00, 16'd5, 4'b1011);
    drive(1, 0, 0, 0, 1, 1, 1, 2'b01, 16'h0, 4'h0);
    drive(1, 0, 0, 1, 0, 0, 1, 2'b10, 16'h0, 4'h0);
    drive(1, 0, 0, 0, 1, 1, 1, 2'b01, 16'h0, 4'h0);
    drive(0, 0, 0, 1, 0, 0, 1, 2'b10, 16'h0, 4'h0);
    tests_run++;
    if (result !== 16'd0 || ovf !== 1'b0 || regBk !== 1'b0 || equals !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset: got result=%0d ovf=%b regBk=%b equals=%b want all 0", result, ovf, regBk, equals);
    end
    l2r_ctrl(16'd7, 4'b1101, eq_seen);
    pow_ref(7, 13, r, o);
    tests_run++;
    if (result !== 16'(r) || ovf !== o || eq_seen !== 4'b1000) begin
      tests_failed++;
      $display("FAIL midop_rerun: got %0d ovf=%b eq=%b want %0d ovf=%b eq=1000", result, ovf, eq_seen, r, o);
    end
  endtask

  task automatic test_random_ops();
    bit rn;
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      rn = ($urandom_range(0, 31) != 0);
      drive(rn, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
      tests_run++;
      if (result !== 16'(m_c) || ovf !== m_ovf || equals !== (m_cnt == 4) || regBk !== m_b[3]) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL random_op %0d: got result=%0d ovf=%b equals=%b regBk=%b want %0d %b %b %b",
                   i, result, ovf, equals, regBk, m_c, m_ovf, (m_cnt == 4), m_b[3]);
        errs++;
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    m_a = 0; m_b = 0; m_c = 0; m_cnt = 0; m_ovf = 0;
    rst_n = 1'b0; base_in = '0; exp_in = '0;
    LoadA = 0; LoadB = 0; ShiftB = 0; LoadCoun = 0; S_Coun = 0; LoadC = 0; S_C = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 16'h0, 4'h0);
    test_reset();
    test_load();
    test_exponent();
    test_overflow();
    test_priority_hold();
    test_reset_mid_op();
    test_random_ops();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
